// File: rtl/core_seq_pkg.sv
// Shared definitions for the multi-cycle memory sequencer: state encoding,
// reset PC default and cycles-per-instruction figures for each instruction class.
package core_seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_FWAIT  = 3'd1,
        S_EXEC   = 3'd2,
        S_LOAD   = 3'd3,
        S_LWAIT  = 3'd4,
        S_STORE  = 3'd5,
        S_COMMIT = 3'd6,
        S_HALTED = 3'd7
    } seq_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned CPI_ALU   = 4;
    localparam int unsigned CPI_STORE = 5;
    localparam int unsigned CPI_LOAD  = 6;

endpackage

// File: rtl/core_mem_sequencer.sv
// Multi-cycle sequencer driving a single-cycle datapath from one unified,
// single-port synchronous memory; owns the PC and issues one commit per instruction.
module core_mem_sequencer
    import core_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] nPc,
    input  logic [ADDR_W-1:0] aluResult,
    input  logic [DATA_W-1:0] regData2,
    input  logic              memWrite,
    input  logic              memRead,
    input  logic              halt,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] memOut,
    output logic [ADDR_W-1:0] pc,
    output logic              core_step,
    output logic              halted,
    output logic              err,
    output logic [31:0]       retired
);

    seq_state_t state_q;
    seq_state_t state_d;

    logic              en_s;
    logic              we_s;
    logic              step_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wdata_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc          <= RESET_PC;
            instruction <= '0;
            memOut      <= '0;
            retired     <= '0;
            err         <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_FETCH: begin
                    if (pc[1:0] != 2'b00)
                        err <= 1'b1;
                end
                S_FWAIT: instruction <= mem_rdata;
                S_EXEC: begin
                    if (memRead && memWrite)
                        err <= 1'b1;
                end
                S_LWAIT: memOut <= mem_rdata;
                S_COMMIT: begin
                    pc      <= nPc;
                    retired <= retired + 32'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        en_s    = 1'b0;
        we_s    = 1'b0;
        step_s  = 1'b0;
        addr_s  = '0;
        wdata_s = '0;
        case (state_q)
            S_FETCH: begin
                en_s    = 1'b1;
                addr_s  = pc;
                state_d = S_FWAIT;
            end
            S_FWAIT: state_d = S_EXEC;
            S_EXEC: begin
                if (memWrite)
                    state_d = S_STORE;
                else if (memRead)
                    state_d = S_LOAD;
                else
                    state_d = S_COMMIT;
            end
            S_LOAD: begin
                en_s    = 1'b1;
                addr_s  = aluResult;
                state_d = S_LWAIT;
            end
            S_LWAIT: state_d = S_COMMIT;
            S_STORE: begin
                en_s    = 1'b1;
                we_s    = 1'b1;
                addr_s  = aluResult;
                wdata_s = regData2;
                state_d = S_COMMIT;
            end
            S_COMMIT: begin
                step_s  = 1'b1;
                state_d = halt ? S_HALTED : S_FETCH;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH, so strobes are masked by reset itself to keep
    // the bus idle while it is held and to drop a write the instant it asserts.
    always_comb begin
        mem_en    = en_s & ~reset;
        mem_we    = we_s & ~reset;
        core_step = step_s & ~reset;
        mem_addr  = reset ? '0 : addr_s;
        mem_wdata = reset ? '0 : wdata_s;
    end

    assign halted = (state_q == S_HALTED);

endmodule

// File: tb/tb_core_mem_sequencer.sv
// Self-checking bench for core_mem_sequencer: a vector table of directed instructions,
// random instruction mix against a transaction-level model, and reset/halt/error sequences.
module tb_core_mem_sequencer;
    import core_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] nPc, aluResult, regData2;
    logic        memWrite, memRead, halt;
    logic [31:0] mem_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] instruction, memOut, pc;
    logic        core_step, halted, err;
    logic [31:0] retired;

    core_mem_sequencer #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .nPc        (nPc),
        .aluResult  (aluResult),
        .regData2   (regData2),
        .memWrite   (memWrite),
        .memRead    (memRead),
        .halt       (halt),
        .mem_rdata  (mem_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .instruction(instruction),
        .memOut     (memOut),
        .pc         (pc),
        .core_step  (core_step),
        .halted     (halted),
        .err        (err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Memory macro stand-in: 256 words, one-cycle synchronous read.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    // Architectural reference state.
    logic [31:0] m_mem [256];
    logic [31:0] m_pc, m_retired, m_memout;
    logic        m_err;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int unsigned model_cpi(input logic rd, input logic wr);
        if (wr) return CPI_STORE;
        if (rd) return CPI_LOAD;
        return CPI_ALU;
    endfunction

    // Runs one instruction starting in FETCH; checks timing, bus traffic and commit effects.
    task automatic run_instr(input logic [31:0] npc_i, input logic [31:0] alu_i,
                             input logic [31:0] wd_i, input logic rd_i, input logic wr_i,
                             input logic hlt_i, input int unsigned exp_cpi);
        int unsigned n = 0;
        int unsigned en_cnt = 0;
        int unsigned we_cnt = 0;
        logic [31:0] fetch_addr = '1;
        logic [31:0] acc_addr = '1;
        logic [31:0] acc_wdata = '1;
        logic        done = 1'b0;
        logic [31:0] exp_instr, exp_memout, a;

        nPc = npc_i; aluResult = alu_i; regData2 = wd_i;
        memRead = rd_i; memWrite = wr_i; halt = hlt_i;

        a = m_pc;
        exp_instr  = m_mem[a[9:2]];
        exp_memout = (rd_i && !wr_i) ? m_mem[alu_i[9:2]] : m_memout;
        if (m_pc[1:0] != 2'b00) m_err = 1'b1;
        if (rd_i && wr_i)       m_err = 1'b1;

        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_en) begin
                en_cnt++;
                if (n == 1) fetch_addr = mem_addr;
                else begin
                    acc_addr  = mem_addr;
                    acc_wdata = mem_wdata;
                end
            end
            if (mem_we) we_cnt++;
            if (core_step) begin
                done = 1'b1;
                chk("instruction_at_commit", instruction, exp_instr);
                chk("memOut_at_commit", memOut, exp_memout);
            end
        end
        chk("commit_seen", {31'b0, done}, 32'd1);
        chk("cycles_per_instr", n, exp_cpi);
        chk("fetch_addr", fetch_addr, m_pc);
        chk("mem_en_cycles", en_cnt, (rd_i || wr_i) ? 32'd2 : 32'd1);
        chk("mem_we_cycles", we_cnt, wr_i ? 32'd1 : 32'd0);
        if (rd_i || wr_i) chk("data_addr", acc_addr, alu_i);
        if (wr_i)         chk("store_wdata", acc_wdata, wd_i);

        if (wr_i) m_mem[alu_i[9:2]] = wd_i;
        m_memout  = exp_memout;
        m_pc      = npc_i;
        m_retired = m_retired + 32'd1;

        @(posedge clk); #1;
        chk("pc_after_commit", pc, m_pc);
        chk("retired", retired, m_retired);
        chk("err", {31'b0, err}, {31'b0, m_err});
        chk("halted", {31'b0, halted}, {31'b0, hlt_i});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_core_step", {31'b0, core_step}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_memOut", memOut, 32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_flags", {30'b0, halted, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m_pc = 32'h0; m_retired = '0; m_memout = '0; m_err = 1'b0;
    endtask

    typedef struct {
        logic [31:0] npc;
        logic [31:0] alu;
        logic [31:0] wd;
        logic        rd;
        logic        wr;
        int unsigned cpi;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int viol;
        int unsigned n;
        logic [31:0] rnpc, ralu, rwd;
        logic rrd, rwr;

        reset = 1'b1; halt = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        nPc = '0; aluResult = '0; regData2 = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = $urandom;
        m_mem[0]    = 32'h0050_0093;
        m_mem[8'h41] = 32'h1234_5678;
        for (int i = 0; i < 256; i++) mem[i] = m_mem[i];

        vecs[0] = '{npc: 32'h04, alu: 32'h0,   wd: 32'h0,         rd: 0, wr: 0, cpi: 4};
        vecs[1] = '{npc: 32'h08, alu: 32'h0,   wd: 32'h0,         rd: 0, wr: 0, cpi: 4};
        vecs[2] = '{npc: 32'h0C, alu: 32'h100, wd: 32'hDEADBEEF,  rd: 0, wr: 1, cpi: 5};
        vecs[3] = '{npc: 32'h10, alu: 32'h104, wd: 32'h0,         rd: 1, wr: 0, cpi: 6};
        vecs[4] = '{npc: 32'h40, alu: 32'h0,   wd: 32'h0,         rd: 0, wr: 0, cpi: 4};
        vecs[5] = '{npc: 32'h44, alu: 32'h100, wd: 32'h0,         rd: 1, wr: 0, cpi: 6};

        do_reset();
        for (int i = 0; i < 6; i++)
            run_instr(vecs[i].npc, vecs[i].alu, vecs[i].wd, vecs[i].rd, vecs[i].wr, 1'b0, vecs[i].cpi);

        for (int i = 0; i < 40; i++) begin
            rnpc = {22'b0, 8'($urandom_range(0, 63)), 2'b00};
            ralu = 32'h100 + {22'b0, 8'($urandom_range(0, 63)), 2'b00};
            rwd  = $urandom;
            rrd  = 1'($urandom_range(0, 1));
            rwr  = rrd ? 1'b0 : 1'($urandom_range(0, 1));
            run_instr(rnpc, ralu, rwd, rrd, rwr, 1'b0, model_cpi(rrd, rwr));
        end

        // Halting instruction commits, then the bus stays idle.
        run_instr(32'h80, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, CPI_ALU);
        halt = 1'b0;
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_en || core_step || !halted) viol++;
        end
        chk("halted_idle_violations", viol, 32'd0);

        do_reset();
        run_instr(32'h04, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, CPI_ALU);

        // Both load and store requested: store wins, error is sticky.
        run_instr(32'h08, 32'h180, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, CPI_STORE);
        run_instr(32'h0C, 32'h180, 32'h0, 1'b1, 1'b0, 1'b0, CPI_LOAD);

        // Misaligned PC is fetched as-is and flags an error.
        do_reset();
        run_instr(32'h02, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, CPI_ALU);
        run_instr(32'h08, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, CPI_ALU);

        // Reset during LWAIT discards the load and idles the bus immediately.
        do_reset();
        nPc = 32'h04; aluResult = 32'h104; memRead = 1'b1; memWrite = 1'b0;
        n = 0;
        while (n < 5) begin
            @(negedge clk);
            n++;
            if (core_step) break;
        end
        chk("lwait_reached", n, 32'd5);
        reset = 1'b1;
        #1;
        chk("midload_mem_en", {31'b0, mem_en}, 32'd0);
        chk("midload_memOut", memOut, 32'h0);
        chk("midload_instruction", instruction, 32'h0);
        chk("midload_retired", retired, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        m_pc = 32'h0; m_retired = '0; m_memout = '0; m_err = 1'b0;
        run_instr(32'h04, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, CPI_ALU);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_mem_sequencer.md
# core_mem_sequencer

Multi-cycle sequencer that runs the single-cycle RISC-V datapath against one single-port, synchronous unified memory (instructions and data share a port, 1-cycle read latency). It fetches each instruction, holds it stable while the datapath settles, performs at most one data access, then pulses a commit strobe so the datapath and register file update exactly once per instruction. It sits between the datapath and the memory macro and owns the architectural PC.

## Interface
- ADDR_W, 32, memory byte-address width
- DATA_W, 32, memory/instruction/data word width
- RESET_PC, 32'h0000_0000, PC after reset

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- nPc  in  ADDR_W  next PC computed by datapath
- aluResult  in  ADDR_W  data address from datapath
- regData2  in  DATA_W  store data from datapath
- memWrite  in  1  store request from control unit
- memRead  in  1  load request (memToReg) from control unit
- halt  in  1  halt decode from control unit
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable (only with mem_en)
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- instruction  out  DATA_W  latched instruction to datapath
- memOut  out  DATA_W  latched load data to datapath
- pc  out  ADDR_W  architectural PC
- core_step  out  1  one-cycle commit strobe (datapath clock enable)
- halted  out  1  sticky halted indication
- err  out  1  sticky protocol error
- retired  out  32  retired-instruction count

## Operation
- States: FETCH, FWAIT, EXEC, LOAD, LWAIT, STORE, COMMIT, HALTED.
- FETCH: mem_en=1, mem_we=0, mem_addr=pc -> FWAIT.
- FWAIT: instruction <= mem_rdata -> EXEC.
- EXEC (datapath settles on held instruction): memWrite -> STORE; else memRead -> LOAD; else -> COMMIT.
- LOAD: mem_en=1, mem_addr=aluResult -> LWAIT. LWAIT: memOut <= mem_rdata -> COMMIT.
- STORE: mem_en=1, mem_we=1, mem_addr=aluResult, mem_wdata=regData2 -> COMMIT.
- COMMIT: core_step=1; pc <= nPc; retired <= retired+1 (wraps mod 2^32); halt=1 -> HALTED, else -> FETCH.
- HALTED: all memory strobes 0, core_step 0, halted=1; left only by reset.
- memRead and memWrite both 1 in EXEC: store wins, err set (sticky until reset).
- pc[1:0] != 0 at FETCH: err set, fetch still issued with address as-is.
- mem_en/mem_we/core_step are Moore outputs decoded from state only; mem_addr/mem_wdata 0 when mem_en=0.

## Timing
- Reset (async, immediate): state=FETCH, pc=RESET_PC, instruction=0, memOut=0, retired=0, halted=0, err=0, mem_en=mem_we=core_step=0 (first FETCH strobe visible the first cycle after reset deasserts).
- Cycles per instruction: ALU/branch/jump 4 (FETCH,FWAIT,EXEC,COMMIT); store 5; load 6.
- instruction stable from cycle after FWAIT through COMMIT; memOut stable from cycle after LWAIT through COMMIT.
- core_step high exactly one cycle per instruction; datapath samples register write and PC on that edge.
- Reset mid-access: mem_we drops asynchronously; partially fetched/loaded data discarded; no commit.
- halt sampled only in COMMIT; the halting instruction itself commits and counts in retired.

## Structure
- Shared package core_seq_pkg: state enum (8 states, 3-bit), RESET_PC default, CPI constants for bench checks.
- Single module; no sub-module needed. Retire counter and error flag inline.

## Test plan
- Reset with RESET_PC=0, memory word 0 = addi x1,x0,5 (nPc=4): FETCH addr 0 one cycle after reset release; core_step on cycle 4; pc=4; retired=1.
- sw at pc=8, aluResult=0x100, regData2=0xDEADBEEF: exactly one cycle with mem_en=mem_we=1, addr 0x100, wdata 0xDEADBEEF; core_step on cycle 5.
- lw, aluResult=0x104, memory holds 0x12345678: memOut=0x12345678 held through COMMIT; core_step on cycle 6; no write strobe.
- Branch taken, nPc=0x40: next FETCH addr 0x40; retired increments by 1.
- Halt instruction: commits, retired increments, halted=1, no further mem_en for 20 cycles; reset restores pc=0, halted=0.
- memRead=memWrite=1 in EXEC: store performed, err=1 sticky; reset asserted during LWAIT: state FETCH, memOut=0, mem_en=0 immediately.
